// File: rtl/axi_read_responder.sv
// AXI4 read-only slave backed by an asynchronous-read word store.
// One burst outstanding at a time: IDLE accepts AR, WAIT models latency, BURST streams R beats.
module axi_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ar_valid,
    output logic                         ar_ready,
    input  logic [ID_WIDTH-1:0]          ar_id,
    input  logic [ADDR_WIDTH-1:0]        ar_addr,
    input  logic [7:0]                   ar_len,
    input  logic [2:0]                   ar_size,
    input  logic [1:0]                   ar_burst,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [ID_WIDTH-1:0]          r_id,
    output logic [DATA_WIDTH-1:0]        r_data,
    output logic [1:0]                   r_resp,
    output logic                         r_last,
    input  logic                         init_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0]        init_wdata
);

    localparam int OFFS  = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_END = 4'(LATENCY - 1);

    localparam logic [1:0] FIXED = 2'd0;
    localparam logic [1:0] INCR  = 2'd1;
    localparam logic [1:0] WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t                  state, state_next;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_next;
    logic [7:0]              len_q, beat_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    slverr_q;
    logic [3:0]              wait_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    ar_hs, r_hs, last_beat, ar_err, in_range;
    logic [ADDR_WIDTH-1:0]   incr, wrap_mask, word_idx, ar_size_mask;

    assign ar_hs     = ar_valid && ar_ready;
    assign r_hs      = r_valid && r_ready;
    assign last_beat = (beat_q == len_q);

    // Whole-burst SLVERR conditions are decided once, at AR acceptance.
    always_comb begin
        ar_size_mask = (ADDR_WIDTH'(1) << ar_size) - ADDR_WIDTH'(1);
        ar_err = 1'b0;
        if (ar_size > 3'(OFFS))
            ar_err = 1'b1;
        if (ar_burst == 2'd3)
            ar_err = 1'b1;
        if (ar_burst == WRAP &&
            (!(ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (ar_addr & ar_size_mask) != '0))
            ar_err = 1'b1;
    end

    always_comb begin
        incr      = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            FIXED:   addr_next = addr_q;
            WRAP:    addr_next = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
            default: addr_next = addr_q + incr;
        endcase
    end

    always_comb begin
        state_next = state;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        r_last     = 1'b0;
        case (state)
            IDLE: begin
                ar_ready = !rst;
                if (ar_hs)
                    state_next = (LATENCY == 0) ? BURST : WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_END)
                    state_next = BURST;
            end
            BURST: begin
                r_valid = 1'b1;
                r_last  = last_beat;
                if (r_hs && last_beat)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range beats get DECERR individually; SLVERR covers the whole burst.
    always_comb begin
        word_idx = addr_q >> OFFS;
        in_range = (word_idx < ADDR_WIDTH'(MEM_DEPTH));
        r_id     = id_q;
        r_resp   = RESP_OKAY;
        r_data   = '0;
        if (r_valid) begin
            if (slverr_q)
                r_resp = RESP_SLVERR;
            else if (!in_range)
                r_resp = RESP_DECERR;
            else
                r_data = mem[word_idx[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            slverr_q <= 1'b0;
            beat_q   <= '0;
            wait_q   <= '0;
        end else begin
            state <= state_next;
            if (ar_hs) begin
                id_q     <= ar_id;
                addr_q   <= ar_addr;
                len_q    <= ar_len;
                size_q   <= ar_size;
                burst_q  <= ar_burst;
                slverr_q <= ar_err;
                beat_q   <= '0;
                wait_q   <= '0;
            end
            if (state == WAIT)
                wait_q <= wait_q + 4'd1;
            if (r_hs) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= addr_next;
            end
        end
    end

    // The store has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= init_wdata;
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: a scoreboard of expected R beats is filled
// when each AR is issued and drained by a negedge monitor.
module tb_axi_read_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_wdata;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] tb_mem [1024];
    int          checks = 0;
    int          errors = 0;

    logic        held_v = 1'b0;
    logic [31:0] held_data;
    logic [1:0]  held_resp;
    logic        held_last;
    logic [3:0]  held_id;

    axi_read_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_id      (ar_id),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .ar_size    (ar_size),
        .ar_burst   (ar_burst),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_id       (r_id),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .r_last     (r_last),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_wdata (init_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compares each accepted beat with the scoreboard and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && r_valid) begin
                chk("hold_data", r_data, held_data);
                chk("hold_resp", 32'(r_resp), 32'(held_resp));
                chk("hold_last", 32'(r_last), 32'(held_last));
                chk("hold_id", 32'(r_id), 32'(held_id));
            end
            if (!r_valid)
                chk("idle_last", 32'(r_last), 32'd0);
            if (r_valid && r_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL extra_beat: observed=beat expected=none data=%0h", r_data);
                end
                if (sb.size() != 0) begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("beat_data", r_data, b.data);
                    chk("beat_resp", 32'(r_resp), 32'(b.resp));
                    chk("beat_last", 32'(r_last), 32'(b.last));
                    chk("beat_id", 32'(r_id), 32'(b.id));
                end
            end
            held_v    = r_valid && !r_ready;
            held_data = r_data;
            held_resp = r_resp;
            held_last = r_last;
            held_id   = r_id;
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        init_we    = 1'b1;
        init_addr  = 10'(idx);
        init_wdata = val;
        tb_mem[idx] = val;
        @(posedge clk);
        #1;
        init_we = 1'b0;
    endtask

    // Pushes the expected beats, then performs the AR handshake.
    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        int          bytes;
        logic [31:0] a, base, win;
        bit          err, ok;
        beat_t       b;
        bytes = 1 << size;
        err = (size > 3'd2) || (burst == 2'd3) ||
              (burst == 2'd2 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (addr % bytes) != 0));
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'd0: a = addr;
                2'd2: begin
                    win  = (32'(len) + 1) * bytes;
                    base = addr - (addr % win);
                    a    = base + (((addr - base) + i * bytes) % win);
                end
                default: a = addr + i * bytes;
            endcase
            b.id   = id;
            b.last = (i == int'(len));
            if (err) begin
                b.resp = 2'd2;
                b.data = 32'd0;
            end else if ((a >> 2) >= 1024) begin
                b.resp = 2'd3;
                b.data = 32'd0;
            end else begin
                b.resp = 2'd0;
                b.data = tb_mem[a >> 2];
            end
            sb.push_back(b);
        end
        ar_valid = 1'b1;
        ar_id    = id;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ar_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ar_valid = 1'b0;
        chk("ar_accept", 32'(ok), 32'd1);
    endtask

    // Drains the scoreboard, optionally stalling with the 1,0,0,1 r_ready pattern.
    task automatic checkOutput(input bit toggle);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 300; c++) begin
            if (sb.size() == 0)
                break;
            r_ready = toggle ? pat[c % 4] : 1'b1;
            @(posedge clk);
            #1;
        end
        r_ready = 1'b1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("end_r_valid", 32'(r_valid), 32'd0);
        chk("end_ar_ready", 32'(ar_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        ar_valid = 1'b0;
        ar_id    = '0;
        ar_addr  = '0;
        ar_len   = '0;
        ar_size  = '0;
        ar_burst = '0;
        r_ready  = 1'b1;
        init_we  = 1'b0;
        init_addr  = '0;
        init_wdata = '0;
        #1;
        chk("rst_ar_ready", 32'(ar_ready), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_last", 32'(r_last), 32'd0);
        chk("rst_r_resp", 32'(r_resp), 32'd0);
        chk("rst_r_id", 32'(r_id), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ar_ready", 32'(ar_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            preload(i, 32'hA0 + 32'(i));
        preload(1022, 32'hB0);
        preload(1023, 32'hB1);

        $display("[TB] INCR len 3 with latency check");
        applyStimulus(4'd5, 32'h0, 8'd3, 3'd2, 2'd1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (r_valid)
                break;
        end
        chk("first_beat_latency", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("consecutive_valid", 32'(r_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        checkOutput(1'b0);

        $display("[TB] WRAP addr 8 len 3");
        applyStimulus(4'd3, 32'h8, 8'd3, 3'd2, 2'd2);
        checkOutput(1'b0);

        $display("[TB] INCR with r_ready stalls");
        applyStimulus(4'd6, 32'h0, 8'd3, 3'd2, 2'd1);
        checkOutput(1'b1);

        $display("[TB] INCR across end of store");
        applyStimulus(4'd7, 32'(1022 * 4), 8'd3, 3'd2, 2'd1);
        checkOutput(1'b0);

        $display("[TB] WRAP with illegal length");
        applyStimulus(4'd1, 32'h0, 8'd2, 3'd2, 2'd2);
        checkOutput(1'b0);

        $display("[TB] FIXED addr 4 len 2");
        applyStimulus(4'd2, 32'h4, 8'd2, 3'd2, 2'd0);
        checkOutput(1'b1);

        $display("[TB] Oversized beat");
        applyStimulus(4'd4, 32'h0, 8'd1, 3'd3, 2'd1);
        checkOutput(1'b0);

        $display("[TB] Reset during second beat");
        applyStimulus(4'd9, 32'h0, 8'd3, 3'd2, 2'd1);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (r_valid) begin
                n = 1;
                break;
            end
        end
        chk("reset_burst_started", 32'(n), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_r_valid", 32'(r_valid), 32'd0);
        chk("mid_rst_r_last", 32'(r_last), 32'd0);
        chk("mid_rst_ar_ready", 32'(ar_ready), 32'd0);
        chk("mid_rst_r_id", 32'(r_id), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_ar_ready", 32'(ar_ready), 32'd1);
        chk("release_r_valid", 32'(r_valid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'd10, 32'h4, 8'd1, 3'd2, 2'd2);
        checkOutput(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the AXI address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the R data width in bits (power of 2, >= 32).
REQ-003 The block SHALL have parameter ID_WIDTH, default 4, meaning the AR/R ID width.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 1024, meaning the backing store size in DATA_WIDTH words.
REQ-005 The block SHALL have parameter LATENCY, default 2, meaning the cycles between AR acceptance and the first R beat (0..15).
REQ-006 The block SHALL have these ports:
  clk  in  1  the single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  ar_valid  in  1  read address valid.
  ar_ready  out  1  read address accepted.
  ar_id  in  ID_WIDTH  transaction ID.
  ar_addr  in  ADDR_WIDTH  byte address of the first beat.
  ar_len  in  8  number of beats minus 1.
  ar_size  in  3  log2 of bytes per beat (<= log2(DATA_WIDTH/8)).
  ar_burst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
  r_valid  out  1  read data valid.
  r_ready  in  1  read data accepted.
  r_id  out  ID_WIDTH  echoed ar_id.
  r_data  out  DATA_WIDTH  read word.
  r_resp  out  2  response: 0 OKAY, 2 SLVERR, 3 DECERR.
  r_last  out  1  final beat of the burst.
  init_we  in  1  backdoor store write enable.
  init_addr  in  log2(MEM_DEPTH)  backdoor word index.
  init_wdata  in  DATA_WIDTH  backdoor write data.

Function
REQ-007 The block SHALL implement the FSM states IDLE, WAIT and BURST, one outstanding transaction at a time.
REQ-008 In IDLE, ar_ready SHALL be 1; on ar_valid&&ar_ready the block SHALL latch id, addr, len, size and burst, and go to WAIT (LATENCY>0) or BURST (LATENCY=0).
REQ-009 In WAIT, a 4-bit counter SHALL count LATENCY cycles and then go to BURST; ar_ready SHALL be 0 in WAIT and BURST.
REQ-010 In BURST, r_valid SHALL be 1 and r_data/r_resp/r_id/r_last SHALL be held stable until r_ready is sampled high.
REQ-011 The beat counter SHALL advance only on r_valid&&r_ready; r_last SHALL be 1 exactly when beat count == latched len.
REQ-012 On the last-beat handshake the FSM SHALL return to IDLE, and ar_ready SHALL be 1 in the following cycle (no back-to-back AR in the same cycle).
REQ-013 The word index SHALL be addr >> log2(DATA_WIDTH/8), and r_data SHALL be the full stored word (no byte-lane masking).
REQ-014 After each beat: FIXED SHALL keep addr; INCR SHALL add (1<<size), wrapping modulo 2^ADDR_WIDTH; WRAP SHALL add (1<<size) within an aligned window of (len+1)<<size bytes, wrapping to the window base.
REQ-015 A WRAP burst with len not in {1,3,7,15}, or with unaligned addr, SHALL return SLVERR on every beat with r_data = 0.
REQ-016 A beat whose word index is >= MEM_DEPTH SHALL return DECERR with r_data = 0; other beats of the same burst SHALL be unaffected.
REQ-017 ar_size > log2(DATA_WIDTH/8) SHALL return SLVERR on all beats.
REQ-018 init_we SHALL write the store at the clock edge in any state; a same-cycle read of the same index SHALL return the old data.
REQ-019 r_data SHALL come combinationally from the current beat address (asynchronous-read store); r_* SHALL be don't-care while r_valid = 0, except that r_last SHALL be 0.

Reset
REQ-020 While rst = 1, the block SHALL force the state to IDLE, ar_ready = 0, r_valid = 0, r_last = 0, r_resp = 0, r_id = 0, and clear the counters; store contents SHALL be unaffected.
REQ-021 ar_ready SHALL rise in the first cycle after rst deasserts.
REQ-022 A reset during WAIT or BURST SHALL abandon the burst immediately, with no further R beats.

Verification
REQ-023 Preload words 0..3 = 0xA0..0xA3; issue INCR, addr 0x0, len 3, size 2, id 5, LATENCY 2, r_ready = 1 -> first r_valid 2 cycles after AR accept, data A0,A1,A2,A3 on consecutive cycles, r_last on the 4th beat only, r_id = 5, OKAY.
REQ-024 Issue WRAP, addr 0x8, len 3, size 2 -> beats from words 2,3,0,1, all OKAY.
REQ-025 Same as REQ-023 with r_ready toggling 1,0,0,1,... -> each beat held stable while stalled, 4 beats delivered in order, no beat lost or duplicated.
REQ-026 INCR, addr (MEM_DEPTH-2)*4, len 3 -> beats 0-1 OKAY with data, beats 2-3 DECERR with data 0.
REQ-027 WRAP, len 2 -> 3 beats, all SLVERR; FIXED, len 2, addr 0x4 -> 3 beats of word 1.
REQ-028 Assert rst during the 2nd beat of a 4-beat burst -> r_valid = 0 immediately, ar_ready = 1 one cycle after release, and a new burst completes correctly.
